clksw_sequencer: RTL and testbench



---
 rtl/clksw_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_clksw_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clksw_sequencer.sv
// clksw_sequencer: drives the hsclk_sel request into the HS/LS CPU clock
// switch and waits for the switch's resynchronised status to confirm the
// requested mode. Mode requests arrive over a valid/ready handshake; done
// pulses once the accepted request has completed. A minimum LS dwell is
// enforced, and transitions that take too long raise a sticky timeout flag.
module clksw_sequencer #(
   parameter int unsigned SYNC_STAGES = 2,   // flops per status resynchroniser, >= 2
   parameter int unsigned TIMEOUT     = 64,  // transition cycles before timeout_err, 1..255
   parameter int unsigned HOLD_CYCLES = 16   // minimum LS dwell after confirmation, 1..255
) (
   input  logic hsclk_in,
   input  logic rst,
   input  logic req_valid,
   input  logic req_ls,
   output logic req_ready,
   output logic done,
   output logic hsclk_sel,
   input  logic hsclk_selected,
   input  logic lsclk_selected,
   output logic ls_active,
   output logic hs_active,
   output logic timeout_err,
   input  logic err_clr
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TO_LAST_C   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_HS      = 3'd0,   // settled in HS, select high
      ST_TO_LS   = 3'd1,   // select low, waiting for LS confirmation
      ST_LS_HOLD = 3'd2,   // LS confirmed, serving the minimum dwell
      ST_LS      = 3'd3,   // settled in LS, select low
      ST_TO_HS   = 3'd4    // select high, waiting for HS confirmation
   } state_t;

   // Status resynchronisers
   logic [SYNC_STAGES-1:0] hs_sync_q;
   logic [SYNC_STAGES-1:0] ls_sync_q;
   logic                   hs_s;
   logic                   ls_s;

   // Sequencer state and counters
   state_t           state_q, state_d;
   logic [CNT_W-1:0] trans_cnt_q, trans_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0] trans_step;

   // Registered outputs
   logic req_ready_q, req_ready_d;
   logic done_q, done_d;
   logic hsclk_sel_q, hsclk_sel_d;
   logic ls_active_q, ls_active_d;
   logic hs_active_q, hs_active_d;
   logic timeout_err_q, timeout_err_d;

   // Decode helpers
   logic accept;
   logic confirm_ls;
   logic confirm_hs;
   logic err_set;

   // Shift the asynchronous switch status through the resynchroniser chains.
   always_ff @(posedge hsclk_in) begin
      // NOTE: the sync chains are reset too, so a stale status captured before
      // reset can never confirm a mode the switch has not reported since.
      if (rst) begin
         hs_sync_q <= '0;
         ls_sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old value
         // of its neighbour; blocking ones would collapse the chain to one flop.
         hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], hsclk_selected};
         ls_sync_q <= {ls_sync_q[SYNC_STAGES-2:0], lsclk_selected};
      end
   end

   assign hs_s = hs_sync_q[SYNC_STAGES-1];
   assign ls_s = ls_sync_q[SYNC_STAGES-1];

   // State, counter and output registers; reset lands in TO_LS because the
   // switch itself resets into LS and that confirmation must still be seen.
   always_ff @(posedge hsclk_in) begin
      if (rst) begin
         state_q       <= ST_TO_LS;
         trans_cnt_q   <= '0;
         hold_cnt_q    <= '0;
         req_ready_q   <= 1'b0;
         done_q        <= 1'b0;
         hsclk_sel_q   <= 1'b0;
         ls_active_q   <= 1'b0;
         hs_active_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         trans_cnt_q   <= trans_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         req_ready_q   <= req_ready_d;
         done_q        <= done_d;
         hsclk_sel_q   <= hsclk_sel_d;
         ls_active_q   <= ls_active_d;
         hs_active_q   <= hs_active_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can
      // leave one unassigned and infer a latch.
      state_d     = state_q;
      trans_cnt_d = trans_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      done_d      = 1'b0;
      err_set     = 1'b0;

      // req_ready_q is high exactly in HS and LS, so it doubles as the
      // "may accept" qualifier.
      accept     = req_valid && req_ready_q;
      confirm_ls = ls_s && !hs_s;
      confirm_hs = hs_s && !ls_s;
      trans_step = (trans_cnt_q == TIMEOUT_C) ? trans_cnt_q : trans_cnt_q + CNT_ONE_C;

      case (state_q)
         ST_HS: begin
            if (accept) begin
               if (req_ls) begin
                  state_d     = ST_TO_LS;
                  trans_cnt_d = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         ST_TO_LS: begin
            if (confirm_ls) begin
               state_d    = ST_LS_HOLD;
               hold_cnt_d = '0;
               done_d     = 1'b1;
            end else begin
               trans_cnt_d = trans_step;
               err_set     = (trans_cnt_q == TO_LAST_C);
            end
         end

         ST_LS_HOLD: begin
            if (hold_cnt_q == HOLD_LAST_C) begin
               state_d = ST_LS;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_ONE_C;
            end
         end

         ST_LS: begin
            if (accept) begin
               if (!req_ls) begin
                  state_d     = ST_TO_HS;
                  trans_cnt_d = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         ST_TO_HS: begin
            if (confirm_hs) begin
               state_d = ST_HS;
               done_d  = 1'b1;
            end else begin
               trans_cnt_d = trans_step;
               err_set     = (trans_cnt_q == TO_LAST_C);
            end
         end

         default: begin
            state_d     = ST_TO_LS;
            trans_cnt_d = '0;
         end
      endcase

      // Outputs are decoded from the next state so they line up with it.
      req_ready_d = (state_d == ST_HS) || (state_d == ST_LS);
      hsclk_sel_d = (state_d == ST_HS) || (state_d == ST_TO_HS);
      ls_active_d = (state_d == ST_LS_HOLD) || (state_d == ST_LS);
      hs_active_d = (state_d == ST_HS);

      // A timeout set beats a simultaneous clear.
      if (err_set) begin
         timeout_err_d = 1'b1;
      end else if (err_clr) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end
   end

   assign req_ready   = req_ready_q;
   assign done        = done_q;
   assign hsclk_sel   = hsclk_sel_q;
   assign ls_active   = ls_active_q;
   assign hs_active   = hs_active_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_clksw_sequencer.sv
// Testbench for clksw_sequencer: directed stimulus with a done-event
// scoreboard. The stimulus pushes the expected done pulses (cycle and
// accompanying status) into a queue; a monitor pops and compares on every
// observed done pulse.
module tb_clksw_sequencer;

   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 64;
   localparam int HOLD_CYCLES = 16;
   localparam int CONF_LAT    = SYNC_STAGES + 1;

   logic hsclk_in = 1'b0;
   logic rst;
   logic req_valid;
   logic req_ls;
   logic req_ready;
   logic done;
   logic hsclk_sel;
   logic hsclk_selected;
   logic lsclk_selected;
   logic ls_active;
   logic hs_active;
   logic timeout_err;
   logic err_clr;

   typedef struct {
      int   cyc;
      logic ls_a;
      logic hs_a;
      logic sel;
      logic terr;
   } exp_t;

   exp_t sb_q[$];
   int   cyc      = 0;
   int   n_pass   = 0;
   int   n_checks = 0;

   clksw_sequencer #(
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT    (TIMEOUT),
      .HOLD_CYCLES(HOLD_CYCLES)
   ) dut (
      .hsclk_in      (hsclk_in),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ls        (req_ls),
      .req_ready     (req_ready),
      .done          (done),
      .hsclk_sel     (hsclk_sel),
      .hsclk_selected(hsclk_selected),
      .lsclk_selected(lsclk_selected),
      .ls_active     (ls_active),
      .hs_active     (hs_active),
      .timeout_err   (timeout_err),
      .err_clr       (err_clr)
   );

   // Free-running clock and cycle counter.
   always #5 hsclk_in = ~hsclk_in;

   always @(posedge hsclk_in) cyc <= cyc + 1;

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Advance n active edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge hsclk_in);
      #1;
   endtask

   task automatic expect_done(input int at, input logic ls_a, input logic hs_a,
                              input logic sel, input logic terr);
      exp_t e;
      e.cyc  = at;
      e.ls_a = ls_a;
      e.hs_a = hs_a;
      e.sel  = sel;
      e.terr = terr;
      sb_q.push_back(e);
   endtask

   task automatic set_status(input logic hs, input logic ls);
      hsclk_selected = hs;
      lsclk_selected = ls;
   endtask

   // Monitor: every done pulse must match the next scoreboard entry.
   always @(negedge hsclk_in) begin : monitor
      exp_t e;
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_bit("unexpected_done", done, 1'b0);
         end else begin
            e = sb_q.pop_front();
            check_int("done_cycle", cyc, e.cyc);
            check_bit("done_ls_active", ls_active, e.ls_a);
            check_bit("done_hs_active", hs_active, e.hs_a);
            check_bit("done_hsclk_sel", hsclk_sel, e.sel);
            check_bit("done_timeout_err", timeout_err, e.terr);
         end
      end
   end

   // Directed stimulus.
   initial begin : stimulus
      int t_entry;
      int t_done;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_ls    = 1'b0;
      err_clr   = 1'b0;
      set_status(1'b0, 1'b1);

      // Reset with the switch reporting LS.
      tick(3);
      check_bit("rst_hsclk_sel", hsclk_sel, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_req_ready", req_ready, 1'b0);
      check_bit("rst_ls_active", ls_active, 1'b0);
      check_bit("rst_hs_active", hs_active, 1'b0);
      check_bit("rst_timeout_err", timeout_err, 1'b0);
      rst = 1'b0;
      expect_done(cyc + CONF_LAT, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1);
      check_bit("post_rst_sel", hsclk_sel, 1'b0);
      check_bit("post_rst_ready", req_ready, 1'b0);
      tick(CONF_LAT - 1);
      check_bit("boot_ls_active", ls_active, 1'b1);
      tick(HOLD_CYCLES - 1);
      check_bit("boot_hold_ready_low", req_ready, 1'b0);
      tick(1);
      check_bit("boot_hold_ready_high", req_ready, 1'b1);
      check_bit("boot_sel_still_low", hsclk_sel, 1'b0);

      // LS -> HS.
      req_valid = 1'b1;
      req_ls    = 1'b0;
      tick(1);
      req_valid = 1'b0;
      check_bit("to_hs_sel", hsclk_sel, 1'b1);
      check_bit("to_hs_ready", req_ready, 1'b0);
      tick(5);
      set_status(1'b1, 1'b0);
      expect_done(cyc + CONF_LAT, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(CONF_LAT);
      check_bit("hs_hs_active", hs_active, 1'b1);
      check_bit("hs_ls_active", ls_active, 1'b0);
      check_bit("hs_ready", req_ready, 1'b1);

      // Same-mode request in HS.
      req_valid = 1'b1;
      req_ls    = 1'b0;
      expect_done(cyc + 1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(1);
      req_valid = 1'b0;
      check_bit("same_sel", hsclk_sel, 1'b1);
      check_bit("same_ready", req_ready, 1'b1);
      tick(1);
      check_bit("same_hs_active", hs_active, 1'b1);
      check_bit("same_ready_after", req_ready, 1'b1);

      // HS -> LS with the switch stuck in HS: timeout, set-wins-over-clear.
      req_valid = 1'b1;
      req_ls    = 1'b1;
      tick(1);
      req_valid = 1'b0;
      t_entry   = cyc;
      check_bit("to_ls_sel", hsclk_sel, 1'b0);
      check_bit("to_ls_hs_active", hs_active, 1'b0);
      tick(TIMEOUT - 4);
      check_bit("to_early_clear", timeout_err, 1'b0);
      err_clr = 1'b1;
      tick(3);
      check_bit("to_not_yet", timeout_err, 1'b0);
      tick(1);
      check_int("to_rise_cycle", cyc - t_entry, TIMEOUT);
      check_bit("to_set_wins", timeout_err, 1'b1);
      err_clr = 1'b0;
      tick(100 - TIMEOUT);
      set_status(1'b0, 1'b1);
      expect_done(cyc + CONF_LAT, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(CONF_LAT);
      t_done = cyc;
      check_bit("late_conf_terr_kept", timeout_err, 1'b1);

      // err_clr, plus a request stalled through LS_HOLD.
      err_clr   = 1'b1;
      req_valid = 1'b1;
      req_ls    = 1'b0;
      check_bit("stall_ready_0", req_ready, 1'b0);
      tick(1);
      err_clr = 1'b0;
      check_bit("err_cleared", timeout_err, 1'b0);
      check_bit("stall_ready_1", req_ready, 1'b0);
      for (int i = 2; i < HOLD_CYCLES; i++) begin
         tick(1);
         check_bit("stall_ready_low", req_ready, 1'b0);
      end
      tick(1);
      check_int("stall_release_cycle", cyc - t_done, HOLD_CYCLES);
      check_bit("stall_ready_high", req_ready, 1'b1);
      check_bit("stall_sel_low", hsclk_sel, 1'b0);
      tick(1);
      req_valid = 1'b0;
      check_bit("stall_accept_sel", hsclk_sel, 1'b1);
      check_bit("stall_accept_ready", req_ready, 1'b0);

      // Inconsistent status during TO_HS: no confirmation until it resolves.
      set_status(1'b1, 1'b1);
      tick(30);
      check_bit("incons_hs_active", hs_active, 1'b0);
      check_bit("incons_sel", hsclk_sel, 1'b1);
      set_status(1'b1, 1'b0);
      expect_done(cyc + CONF_LAT, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(CONF_LAT);
      check_bit("incons_resolved_ready", req_ready, 1'b1);
      check_bit("incons_no_timeout", timeout_err, 1'b0);

      // Back to LS, then into TO_HS again and reset while stuck there.
      req_valid = 1'b1;
      req_ls    = 1'b1;
      tick(1);
      req_valid = 1'b0;
      set_status(1'b0, 1'b1);
      expect_done(cyc + CONF_LAT, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(CONF_LAT + HOLD_CYCLES);
      check_bit("ls2_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_ls    = 1'b0;
      tick(1);
      req_valid = 1'b0;
      check_bit("to_hs2_sel", hsclk_sel, 1'b1);
      set_status(1'b1, 1'b1);
      tick(TIMEOUT);
      check_bit("to_hs2_timeout", timeout_err, 1'b1);
      tick(6);
      rst = 1'b1;
      tick(1);
      check_bit("midrst_sel", hsclk_sel, 1'b0);
      check_bit("midrst_terr", timeout_err, 1'b0);
      check_bit("midrst_ready", req_ready, 1'b0);
      check_bit("midrst_hs_active", hs_active, 1'b0);
      set_status(1'b0, 1'b1);
      tick(2);
      rst = 1'b0;
      expect_done(cyc + CONF_LAT, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(CONF_LAT);
      check_bit("rst2_ls_active", ls_active, 1'b1);
      tick(2);

      check_int("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
